// File: rtl/pe_psum_collector.sv
// pe_psum_collector: consumer end of a PE row.
// Sums NUM_PE signed 16-bit products per beat, accumulates ACC_LEN beats into one
// raw psum, then requantizes it to int8 (arithmetic shift, optional ReLU, saturate).
// The result register is separate from the accumulator, so the next group can
// accumulate while the previous result waits on out_ready.
module pe_psum_collector #(
  parameter int NUM_PE  = 3,
  parameter int ACC_LEN = 9,
  parameter int ACC_W   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_PE*16-1:0]   products,
  input  logic [4:0]             cfg_shift,
  input  logic                   cfg_relu,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_data,
  output logic [ACC_W-1:0]       out_psum,
  output logic                   busy
);

  localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ACC_LEN - 1);
  localparam logic signed [ACC_W-1:0] QMAX = 127;
  localparam logic signed [ACC_W-1:0] QMIN = -128;

  logic signed [ACC_W-1:0] acc;
  logic        [CNT_W-1:0] count;
  logic signed [ACC_W-1:0] ext [NUM_PE];
  logic signed [ACC_W-1:0] bsum, fin, shr, rel;
  logic        [7:0]       q;
  logic                    fire, last;

  // sign-extend each PE product to accumulator width
  for (genvar i = 0; i < NUM_PE; i++) begin : g_ext
    assign ext[i] = {{(ACC_W-16){products[16*i+15]}}, products[16*i +: 16]};
  end

  // beat sum across all PEs
  always_comb begin
    bsum = '0;
    for (int i = 0; i < NUM_PE; i++) bsum = bsum + ext[i];
  end

  // last beat is held off while a result is still pending; depends on state only
  assign in_ready = !(out_valid && count == LAST);
  assign fire     = in_valid && in_ready;
  assign last     = (count == LAST);
  assign fin      = acc + bsum;
  assign busy     = (count != '0) || out_valid;

  // requant: floor shift, optional ReLU, saturate to int8
  always_comb begin
    shr = fin >>> cfg_shift;
    rel = (cfg_relu && shr[ACC_W-1]) ? '0 : shr;
    if (rel > QMAX)      q = 8'h7f;
    else if (rel < QMIN) q = 8'h80;
    else                 q = rel[7:0];
  end

  // accumulator, beat counter and result register; clear wins over everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_psum  <= '0;
    end else if (clear) begin
      acc       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (fire) begin
        if (last) begin
          out_psum  <= fin;
          out_data  <= q;
          out_valid <= 1'b1;
          acc       <= '0;
          count     <= '0;
        end else begin
          acc   <= fin;
          count <= count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_psum_collector.sv
// Directed bench for pe_psum_collector: a default instance (ACC_LEN=9) and an
// ACC_LEN=1 instance for single-beat rounding checks.
module tb_pe_psum_collector;

  logic        clk, rst, clear;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [47:0] products;
  logic [4:0]  cfg_shift;
  logic        cfg_relu;
  logic [7:0]  out_data;
  logic [31:0] out_psum;

  logic        in1_valid, in1_ready, out1_valid, out1_ready, busy1;
  logic [47:0] products1;
  logic [4:0]  shift1;
  logic [7:0]  out1_data;
  logic [31:0] out1_psum;

  int nchk = 0;
  int nerr = 0;

  pe_psum_collector #(.NUM_PE(3), .ACC_LEN(9), .ACC_W(32)) u_dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .products(products), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_psum(out_psum), .busy(busy));

  pe_psum_collector #(.NUM_PE(3), .ACC_LEN(1), .ACC_W(32)) u_dut1 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in1_valid), .in_ready(in1_ready),
    .products(products1), .cfg_shift(shift1), .cfg_relu(1'b0),
    .out_valid(out1_valid), .out_ready(out1_ready), .out_data(out1_data),
    .out_psum(out1_psum), .busy(busy1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] pk(input int a2, input int a1, input int a0);
    logic [15:0] x2, x1, x0;
    x2 = 16'(a2); x1 = 16'(a1); x0 = 16'(a0);
    return {x2, x1, x0};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // present n beats back to back, expecting each to be accepted
  task automatic push(input logic [47:0] p, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; products = p;
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; products = '0;
    cfg_shift = '0; cfg_relu = 1'b0; out_ready = 1'b0;
    in1_valid = 1'b0; products1 = '0; shift1 = '0; out1_ready = 1'b0;
    step(); step();
    rst = 1'b0; step();

    // reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", $signed(out_data), 0);
    chk("rst_out_psum", $signed(out_psum), 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);

    // basic group: 9 x (5 - 3 + 0) = 18
    push(pk(0, -3, 5), 1);
    chk("basic_busy_b1", busy, 1);
    push(pk(0, -3, 5), 7);
    chk("basic_no_valid_b8", out_valid, 0);
    push(pk(0, -3, 5), 1);
    chk("basic_valid", out_valid, 1);
    chk("basic_psum", $signed(out_psum), 18);
    chk("basic_data", $signed(out_data), 18);
    chk("basic_busy_pending", busy, 1);
    drain();
    chk("basic_drained", out_valid, 0);
    chk("basic_busy_idle", busy, 0);

    // negative saturation: -2700 >>> 4 = -169 -> -128
    cfg_shift = 5'd4;
    push(pk(-100, -100, -100), 9);
    chk("neg_psum", $signed(out_psum), -2700);
    chk("neg_data", $signed(out_data), -128);
    drain();
    cfg_relu = 1'b1;
    push(pk(-100, -100, -100), 9);
    chk("relu_psum", $signed(out_psum), -2700);
    chk("relu_data", $signed(out_data), 0);
    drain();
    cfg_relu = 1'b0;

    // positive saturation: 27000 >>> 2 = 6750 -> 127
    cfg_shift = 5'd2;
    push(pk(1000, 1000, 1000), 9);
    chk("pos_psum", $signed(out_psum), 27000);
    chk("pos_data", $signed(out_data), 127);
    drain();
    cfg_shift = 5'd0;

    // ACC_LEN=1 floor rounding: 7>>>1=3, -7>>>1=-4
    shift1 = 5'd1;
    in1_valid = 1'b1; products1 = pk(0, 0, 7); step(); in1_valid = 1'b0;
    chk("l1_pos_valid", out1_valid, 1);
    chk("l1_pos_data", $signed(out1_data), 3);
    out1_ready = 1'b1; step(); out1_ready = 1'b0;
    in1_valid = 1'b1; products1 = pk(0, -2, -5); step(); in1_valid = 1'b0;
    chk("l1_neg_psum", $signed(out1_psum), -7);
    chk("l1_neg_data", $signed(out1_data), -4);
    out1_ready = 1'b1; step(); out1_ready = 1'b0;
    chk("l1_drained", out1_valid, 0);

    // backpressure: A pending, B streams 8 beats then stalls on its 9th
    push(pk(0, -3, 5), 9);
    chk("bp_a_valid", out_valid, 1);
    push(pk(0, 0, 1), 8);
    chk("bp_stall_ready", in_ready, 0);
    in_valid = 1'b1; products = pk(0, 0, 1);
    step(); step();
    chk("bp_still_stalled", in_ready, 0);
    chk("bp_a_stable", $signed(out_data), 18);
    chk("bp_a_psum_stable", $signed(out_psum), 18);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("bp_a_drained", out_valid, 0);
    chk("bp_ready_again", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("bp_b_valid", out_valid, 1);
    chk("bp_b_psum", $signed(out_psum), 9);
    drain();

    // clear mid-group with a valid beat present
    push(pk(0, 0, 10), 4);
    chk("clr_busy_before", busy, 1);
    in_valid = 1'b1; products = pk(0, 0, 10); clear = 1'b1;
    step();
    clear = 1'b0; in_valid = 1'b0;
    chk("clr_busy_after", busy, 0);
    chk("clr_no_valid", out_valid, 0);
    push(pk(0, 0, 1), 9);
    chk("clr_next_psum", $signed(out_psum), 9);
    chk("clr_next_data", $signed(out_data), 9);
    drain();

    // async reset with result pending
    push(pk(0, -3, 5), 9);
    chk("ar_valid_before", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_out_data", $signed(out_data), 0);
    chk("ar_out_psum", $signed(out_psum), 0);
    #1 rst = 1'b0;
    #1;
    chk("ar_in_ready", in_ready, 1);
    chk("ar_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/pe_psum_collector.md
Name: pe_psum_collector

Overview:
- Consumer end of the PE row. Each cycle it takes the signed 16-bit products from NUM_PE PEs and sums them with an adder tree.
- It accumulates that sum over ACC_LEN input beats, one group per output pixel (kernel rows × channels).
- At group end it requantizes the result to int8 with arithmetic shift, optional ReLU and saturation.
- Output uses a valid/ready handshake. A result register lets the next group accumulate while the previous result waits for the consumer.

Parameters:
- NUM_PE, 3, number of PE products presented per beat.
- ACC_LEN, 9, input beats per output result; must be ≥1.
- ACC_W, 32, accumulator and raw psum width; must be ≥ 16+clog2(NUM_PE*ACC_LEN).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- clear  in  1  synchronous abort: drops the partial group and any pending result.
- in_valid  in  1  products valid this cycle.
- in_ready  out  1  collector accepts the beat this cycle.
- products  in  NUM_PE*16  packed signed products; PE i occupies [16i+15:16i].
- cfg_shift  in  5  requant arithmetic right-shift amount.
- cfg_relu  in  1  1 = clamp negative results to 0.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  8  signed requantized result.
- out_psum  out  ACC_W  signed raw accumulated sum (before shift).
- busy  out  1  partial group in progress or result pending.

Behaviour:
- Reset and clock: rst is asynchronous, active-high; clock clk.
- Reset state: acc=0, count=0, out_valid=0, out_data=0, out_psum=0. Outputs then evaluate to busy=0, in_ready=1.
- Beat accept (fire): in_valid && in_ready.
- Beat sum: sum of all NUM_PE products, each sign-extended to ACC_W.
- Accumulation on fire, not last beat (count<ACC_LEN-1): acc <= acc + beat sum; count <= count+1.
- Accumulation on fire, last beat (count==ACC_LEN-1):
  - final = acc + beat sum.
  - out_psum <= final; out_data <= requant(final); out_valid <= 1.
  - acc <= 0; count <= 0.
  - cfg_shift and cfg_relu are sampled in this cycle only.
- Latency: last beat accepted in cycle T → out_valid=1 at T+1.
- Requant, in order:
  - r = final >>> cfg_shift (arithmetic, floor toward −inf).
  - If cfg_relu && r<0, r=0.
  - Saturate r to [−128, 127].
- Accumulator overflow: two's-complement wrap mod 2^ACC_W, no saturation. This cannot occur within parameter constraints.
- Output handshake:
  - out_valid && out_ready → out_valid <= 0. out_data and out_psum hold their last value.
  - While out_valid=1 and out_ready=0, out_data and out_psum are stable.
- in_ready = !(out_valid && count==ACC_LEN-1). It is purely a function of registered state, with no combinational path from out_ready or in_valid.
  - The last beat of a group stalls while a result is pending, even if out_ready=1 in that cycle. It is accepted the cycle after the pending result drains.
  - For ACC_LEN=1, peak throughput is therefore one result per 2 cycles under continuous traffic.
- Simultaneous output drain and last-beat fire: not possible, because in_ready=0 in that case.
- Simultaneous output drain and non-last-beat fire: both take effect in the same cycle.
- in_valid && !in_ready: beat is not consumed; the producer must hold products.
- clear (priority over all other synchronous events):
  - acc=0, count=0, out_valid=0; any beat presented that cycle is discarded.
  - out_data and out_psum keep their values.
- busy = (count!=0) || out_valid.
- Reset mid-operation: all state returns to reset values immediately (out_valid falls without waiting for a clock edge); the partial group is lost.

Test Plan:
- Basic group: products {PE2,PE1,PE0}={0,−3,5} for 9 beats, shift=0, relu=0 → out_psum=18 and out_data=18, with out_valid rising the cycle after beat 9; busy=1 from beat 1 until drain.
- Negative saturation and ReLU: each product −100 (beat sum −300), 9 beats, shift=4 → out_psum=−2700, r=−169, out_data=−128. Repeat with relu=1 → out_data=0, out_psum=−2700.
- Positive saturation and floor rounding:
  - Each product 1000, shift=2 → out_psum=27000, out_data=127.
  - Product sum 7 for 1 beat with ACC_LEN=1, shift=1 → 3.
  - Sum −7, shift=1 → −4.
- Backpressure: hold out_ready=0 after group A and stream group B continuously.
  - 8 B beats are accepted; in_ready=0 on the 9th.
  - Raise out_ready for 1 cycle → A drains, the 9th B beat is accepted next cycle, and B's out_valid follows one cycle later.
  - A's out_data is stable throughout the stall.
- clear: after 4 beats of sum 10, pulse clear together with a valid beat → count=0, busy=0, beat discarded. The following full group of sum 1 gives out_psum=9.
- Async reset while out_valid=1 and out_ready=0: out_valid, out_data and out_psum go to 0 without a clock edge; after release, in_ready=1 and busy=0.
